mem_dsram_ctrl: RTL and testbench
=================================

# mem_dsram_ctrl

Sequencer between the MEM pipeline stage and a variable-latency data SRAM using a req/addr_ok/data_ok handshake. It captures one load or store from MEM and drives the SRAM request. It generates MEM's ready_go stall signal and returns aligned, sign-extended load data. A watchdog and an alignment check turn a hung bus or an illegal access into an error completion, so the pipeline never deadlocks.

## Interface
- TIMEOUT, default 255: maximum cycles spent in ADDR+DATA before a forced error completion; must be ≥ 2.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- mem_valid  in  1  MEM stage holds a valid instruction.
- mem_access  in  1  instruction is a load or store.
- mem_we  in  1  1 = store, 0 = load.
- mem_byte  in  1  1 = byte access (LB/SB), 0 = word access.
- mem_addr  in  32  effective address.
- mem_wdata  in  32  store data; the low byte is used for SB.
- wb_allow_in  in  1  WB stage can accept.
- mem_ready_go  out  1  MEM may advance.
- mem_rdata  out  32  load result: a word, or a sign-extended byte.
- mem_err  out  1  current access completed with an error (misaligned access or timeout).
- data_sram_req  out  1  request valid.
- data_sram_wr  out  1  write request.
- data_sram_size  out  2  0 = byte, 2 = word.
- data_sram_wstrb  out  4  byte enables.
- data_sram_addr  out  32  request address.
- data_sram_wdata  out  32  write data.
- data_sram_addr_ok  in  1  request accepted.
- data_sram_data_ok  in  1  read data valid or write complete.
- data_sram_rdata  in  32  read data.

## Operation
- States: IDLE, ADDR, DATA, HOLD.
- IDLE, when mem_valid & mem_access:
  - Capture we, byte, addr, wdata into request registers.
  - Go to HOLD with err=1 if the access is word-sized and addr[1:0]≠0; no SRAM request is issued.
  - Otherwise go to ADDR.
- ADDR:
  - Request outputs are driven from the registers.
  - On addr_ok, go to DATA.
- DATA:
  - On data_ok, latch rdata (loads) and go to HOLD.
- HOLD:
  - Result is held stable.
  - When wb_allow_in, go to IDLE.
- mem_ready_go:
  - 1 when !mem_valid or !mem_access.
  - Otherwise 1 only in HOLD.
- wstrb:
  - Byte access: 4'b0001 << addr[1:0].
  - Word access: 4'b1111.
  - Byte stores replicate wdata[7:0] to all four lanes.
- Load byte: select lane addr[1:0] of the latched data and sign-extend bit 7 of that lane. Load word: pass through unchanged. Stores return mem_rdata=0.
- Watchdog:
  - 8+ bit counter, cleared on entry to ADDR; it increments each cycle in ADDR or DATA.
  - Reaching TIMEOUT-1 without the needed handshake forces HOLD with err=1 and rdata=0.
  - A request is never deasserted in ADDR except by timeout.
- data_ok while in IDLE, ADDR or HOLD (stale or after timeout) is ignored.
- addr_ok outside ADDR is ignored.

## Timing
- Reset (asynchronous, immediate):
  - state=IDLE, counter=0.
  - All latched registers are 0, so every output except mem_ready_go is 0. mem_ready_go follows its combinational rule (1 when mem_valid=0).
  - An in-flight transaction is abandoned; its later data_ok is ignored.
- data_sram_req is high only in ADDR and is registered.
- addr_ok may arrive in the first ADDR cycle. data_ok earliest arrives the cycle after the addr_ok handshake.
- Best-case load/store, with addr_ok and data_ok each immediate:
  - cycle 0: IDLE detects the access.
  - cycle 1: ADDR, addr_ok.
  - cycle 2: DATA, data_ok.
  - cycle 3: HOLD, mem_ready_go=1.
- Misaligned access: HOLD with mem_err=1 one cycle after detection.
- HOLD→IDLE on the same edge at which MEM's input register loads the next instruction, so the next access is detected in the following cycle and no access is issued twice.
- mem_rdata and mem_err are stable throughout HOLD. They are cleared on entry to ADDR or the misaligned-error HOLD path.
- Non-memory instructions never leave IDLE and add zero latency.

## Test plan
- LW addr 0x100: addr_ok on the 1st ADDR cycle, data_ok 2 cycles later with rdata=0x8765_4321 → req high exactly 1 cycle with size=2 and wstrb=0, then ready_go; mem_rdata=0x8765_4321, err=0.
- LB addr 0x103 with rdata=0x80FF_0000 → size=0, mem_rdata=0xFFFF_FF80. LB addr 0x102 with the same data → mem_rdata=0xFFFF_FFFF.
- SB addr 0x201 with wdata=0x0000_00AB → wr=1, wstrb=4'b0010, data_sram_wdata=0xABAB_ABAB.
- LW addr 0x102 → no req ever asserted; HOLD after 1 cycle with err=1 and rdata=0.
- Downstream stall: hold wb_allow_in=0 for 5 cycles in HOLD → result and ready_go stay stable, and only one req is issued.
- Failure paths:
  - Addr_ok never arrives with TIMEOUT=8 → HOLD with err=1 after 8 cycles; a late data_ok is ignored.
  - Assert reset during DATA → outputs clear immediately; a following access proceeds normally.

Source files
------------

// File: rtl/mem_dsram_ctrl.sv
// MEM-stage sequencer for a req/addr_ok/data_ok data SRAM: one access at a time,
// with a watchdog and an alignment check that turn faults into error completions.
module mem_dsram_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic        mem_access,
    input  logic        mem_we,
    input  logic        mem_byte,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        wb_allow_in,
    output logic        mem_ready_go,
    output logic [31:0] mem_rdata,
    output logic        mem_err,
    output logic        data_sram_req,
    output logic        data_sram_wr,
    output logic [1:0]  data_sram_size,
    output logic [3:0]  data_sram_wstrb,
    output logic [31:0] data_sram_addr,
    output logic [31:0] data_sram_wdata,
    input  logic        data_sram_addr_ok,
    input  logic        data_sram_data_ok,
    input  logic [31:0] data_sram_rdata
);

    localparam int unsigned CW = ($clog2(TIMEOUT) > 8) ? $clog2(TIMEOUT) : 8;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, HOLD} state_t;

    state_t        state_q, state_d;
    logic          we_q, byte_q, err_q;
    logic [31:0]   addr_q, wdata_q, rdata_q;
    logic [CW-1:0] cnt_q;
    logic          start, misalign, expired;
    logic [7:0]    lane;

    assign start    = mem_valid & mem_access;
    assign misalign = !mem_byte && (mem_addr[1:0] != 2'b00);
    assign expired  = cnt_q >= CW'(TIMEOUT - 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // A handshake arriving on the last watchdog cycle still wins over the timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = misalign ? HOLD : ADDR;
            ADDR: if (data_sram_addr_ok) state_d = DATA;
                  else if (expired)      state_d = HOLD;
            DATA: if (data_sram_data_ok || expired) state_d = HOLD;
            HOLD: if (wb_allow_in) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_q    <= 1'b0;
            byte_q  <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    we_q    <= mem_we;
                    byte_q  <= mem_byte;
                    addr_q  <= mem_addr;
                    wdata_q <= mem_wdata;
                    err_q   <= misalign;
                    rdata_q <= '0;
                    cnt_q   <= '0;
                end
                ADDR: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (!data_sram_addr_ok && expired) err_q <= 1'b1;
                end
                DATA: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (data_sram_data_ok) rdata_q <= we_q ? '0 : data_sram_rdata;
                    else if (expired)      err_q   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        data_sram_req   = (state_q == ADDR);
        data_sram_wr    = data_sram_req & we_q;
        data_sram_size  = (data_sram_req && !byte_q) ? 2'd2 : 2'd0;
        data_sram_wstrb = '0;
        if (data_sram_req && we_q) data_sram_wstrb = byte_q ? (4'b0001 << addr_q[1:0]) : 4'b1111;
        data_sram_addr  = data_sram_req ? addr_q : '0;
        data_sram_wdata = '0;
        if (data_sram_req) data_sram_wdata = byte_q ? {4{wdata_q[7:0]}} : wdata_q;
        case (addr_q[1:0])
            2'd0:    lane = rdata_q[7:0];
            2'd1:    lane = rdata_q[15:8];
            2'd2:    lane = rdata_q[23:16];
            default: lane = rdata_q[31:24];
        endcase
        if (we_q)        mem_rdata = '0;
        else if (byte_q) mem_rdata = {{24{lane[7]}}, lane};
        else             mem_rdata = rdata_q;
        mem_err      = err_q;
        mem_ready_go = !start || (state_q == HOLD);
    end

endmodule

// File: tb/tb_mem_dsram_ctrl.sv
// Directed self-checking bench for mem_dsram_ctrl; the SRAM side is driven by hand.
module tb_mem_dsram_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mem_valid = 1'b0, mem_access = 1'b0, mem_we = 1'b0, mem_byte = 1'b0;
    logic [31:0] mem_addr = '0, mem_wdata = '0;
    logic        wb_allow_in = 1'b0;
    logic        mem_ready_go, mem_err;
    logic [31:0] mem_rdata;
    logic        data_sram_req, data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr, data_sram_wdata;
    logic        data_sram_addr_ok = 1'b0, data_sram_data_ok = 1'b0;
    logic [31:0] data_sram_rdata = '0;

    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned req_cnt = 0;
    logic [1:0]  last_size;
    logic [3:0]  last_wstrb;
    logic        last_wr;
    logic [31:0] last_addr, last_wdata;

    mem_dsram_ctrl #(.TIMEOUT(8)) dut (
        .clk(clk), .reset(reset),
        .mem_valid(mem_valid), .mem_access(mem_access), .mem_we(mem_we), .mem_byte(mem_byte),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .wb_allow_in(wb_allow_in),
        .mem_ready_go(mem_ready_go), .mem_rdata(mem_rdata), .mem_err(mem_err),
        .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
        .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
        .data_sram_rdata(data_sram_rdata)
    );

    always #5 clk = ~clk;

    // Snapshot of the request bus, sampled mid-cycle while req is high.
    always @(negedge clk) begin
        if (data_sram_req) begin
            req_cnt    <= req_cnt + 1;
            last_size  <= data_sram_size;
            last_wstrb <= data_sram_wstrb;
            last_wr    <= data_sram_wr;
            last_addr  <= data_sram_addr;
            last_wdata <= data_sram_wdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Entered in IDLE at posedge+2; leaves in HOLD at posedge+2.
    task automatic txn(input logic we, input logic byt, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rdat,
                       input int ad_dly, input int dt_dly);
        mem_valid = 1'b1; mem_access = 1'b1; mem_we = we; mem_byte = byt;
        mem_addr = addr; mem_wdata = wdata; wb_allow_in = 1'b0;
        tick();
        for (int i = 0; i < ad_dly; i++) tick();
        data_sram_addr_ok = 1'b1;
        tick();
        data_sram_addr_ok = 1'b0;
        for (int i = 1; i < dt_dly; i++) tick();
        data_sram_data_ok = 1'b1; data_sram_rdata = rdat;
        tick();
        data_sram_data_ok = 1'b0;
    endtask

    task automatic release_hold();
        wb_allow_in = 1'b1; mem_valid = 1'b0; mem_access = 1'b0;
        tick();
        wb_allow_in = 1'b0;
    endtask

    initial begin
        int n;
        logic [31:0] base;

        #1 reset = 1'b1;
        #2;
        chk("rst_ready_go", {31'b0, mem_ready_go}, 32'd1);
        chk("rst_req",      {31'b0, data_sram_req}, 32'd0);
        chk("rst_rdata",    mem_rdata, 32'h0);
        chk("rst_err",      {31'b0, mem_err}, 32'd0);
        chk("rst_size",     {30'b0, data_sram_size}, 32'd0);
        @(posedge clk); #2 reset = 1'b0;

        // LW 0x100, addr_ok immediate, data_ok two cycles later, then a 5-cycle WB stall
        mem_valid = 1'b1; mem_access = 1'b1; mem_we = 1'b0; mem_byte = 1'b0; mem_addr = 32'h100;
        #1 chk("lw_detect_stall", {31'b0, mem_ready_go}, 32'd0);
        #1 base = req_cnt;
        txn(1'b0, 1'b0, 32'h100, 32'h0, 32'h8765_4321, 0, 2);
        chk("lw_ready_go", {31'b0, mem_ready_go}, 32'd1);
        chk("lw_rdata",    mem_rdata, 32'h8765_4321);
        chk("lw_err",      {31'b0, mem_err}, 32'd0);
        chk("lw_req_cnt",  req_cnt - base, 32'd1);
        chk("lw_size",     {30'b0, last_size}, 32'd2);
        chk("lw_wstrb",    {28'b0, last_wstrb}, 32'd0);
        chk("lw_wr",       {31'b0, last_wr}, 32'd0);
        chk("lw_addr",     last_addr, 32'h100);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_ready_go", {31'b0, mem_ready_go}, 32'd1);
            chk("stall_rdata",    mem_rdata, 32'h8765_4321);
        end
        chk("stall_req_cnt", req_cnt - base, 32'd1);
        release_hold();

        // LB from the upper two lanes of the same word
        txn(1'b0, 1'b1, 32'h103, 32'h0, 32'h80FF_0000, 0, 1);
        chk("lb3_rdata", mem_rdata, 32'hFFFF_FF80);
        chk("lb3_size",  {30'b0, last_size}, 32'd0);
        release_hold();
        txn(1'b0, 1'b1, 32'h102, 32'h0, 32'h80FF_0000, 1, 1);
        chk("lb2_rdata", mem_rdata, 32'hFFFF_FFFF);
        release_hold();

        // Misaligned LW: error completion next cycle, no request
        base = req_cnt;
        mem_valid = 1'b1; mem_access = 1'b1; mem_we = 1'b0; mem_byte = 1'b0; mem_addr = 32'h102;
        tick();
        chk("mis_ready_go", {31'b0, mem_ready_go}, 32'd1);
        chk("mis_err",      {31'b0, mem_err}, 32'd1);
        chk("mis_rdata",    mem_rdata, 32'h0);
        chk("mis_req_cnt",  req_cnt - base, 32'd0);
        release_hold();

        // SB 0x201
        txn(1'b1, 1'b1, 32'h201, 32'h0000_00AB, 32'hDEAD_BEEF, 0, 1);
        chk("sb_wr",    {31'b0, last_wr}, 32'd1);
        chk("sb_wstrb", {28'b0, last_wstrb}, 32'h2);
        chk("sb_wdata", last_wdata, 32'hABAB_ABAB);
        chk("sb_size",  {30'b0, last_size}, 32'd0);
        chk("sb_rdata", mem_rdata, 32'h0);
        chk("sb_err",   {31'b0, mem_err}, 32'd0);
        release_hold();

        // addr_ok never arrives: 8 ADDR cycles then error HOLD
        base = req_cnt;
        mem_valid = 1'b1; mem_access = 1'b1; mem_we = 1'b0; mem_byte = 1'b0; mem_addr = 32'h300;
        n = 0;
        do begin
            tick();
            n++;
        end while (!mem_ready_go && n < 30);
        chk("to_cycles",  n, 32'd9);
        chk("to_req_cnt", req_cnt - base, 32'd8);
        chk("to_err",     {31'b0, mem_err}, 32'd1);
        chk("to_rdata",   mem_rdata, 32'h0);
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h1234_5678;
        tick();
        data_sram_data_ok = 1'b0;
        chk("to_late_rdata", mem_rdata, 32'h0);
        chk("to_late_err",   {31'b0, mem_err}, 32'd1);
        release_hold();

        // Reset while in DATA, stale data_ok afterwards, then a clean access
        mem_valid = 1'b1; mem_access = 1'b1; mem_we = 1'b0; mem_byte = 1'b0; mem_addr = 32'h400;
        data_sram_addr_ok = 1'b1;
        tick();
        tick();
        data_sram_addr_ok = 1'b0;
        #1 reset = 1'b1;
        #1;
        chk("rst_data_req",      {31'b0, data_sram_req}, 32'd0);
        chk("rst_data_err",      {31'b0, mem_err}, 32'd0);
        chk("rst_data_ready_go", {31'b0, mem_ready_go}, 32'd0);
        #1 reset = 1'b0;
        mem_valid = 1'b0; mem_access = 1'b0;
        base = req_cnt;
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #2;
        data_sram_data_ok = 1'b0;
        chk("stale_rdata",   mem_rdata, 32'h0);
        chk("stale_req_cnt", req_cnt - base, 32'd0);
        txn(1'b0, 1'b0, 32'h104, 32'h0, 32'h0BAD_F00D, 0, 1);
        chk("post_rst_rdata", mem_rdata, 32'h0BAD_F00D);
        chk("post_rst_err",   {31'b0, mem_err}, 32'd0);
        chk("post_rst_req",   req_cnt - base, 32'd1);
        release_hold();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
